// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one word-aligned imem read at a time and
// buffers the returned instruction for decode. Redirects squash any wrong-path fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
          // A redirect racing the accept leaves an old-address request in flight.
          kill_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        // A redirect drops the buffer; instr_valid is gated so no transfer happens.
        if (redirect_valid || instr_ready) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReq;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      kill_q     <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req_valid = (state_q == StReq) & ~reset;
  assign imem_addr      = {pc_q[31:2], 2'b00};
  assign instr_valid    = (state_q == StHold) & ~redirect_valid & ~reset;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (next PC to deliver, outstanding request, buffer full).
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  int checks = 0;
  int failures = 0;

  // Model state: what the fetch unit owes decode, seen from outside.
  bit          pending = 0;    // a request was accepted and its response not yet returned
  bit          squash = 0;     // that request was overtaken by a redirect
  bit          buf_full = 0;   // a good-path instruction is waiting for decode
  bit          prev_rst = 0;
  bit          pend_dbeef = 0;
  bit          dbeef = 0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst, input bit rrdy, input bit ird, input bit redir,
                      input logic [31:0] rpc, input bit stray);
    bit rsp, exp_rv, exp_iv, xfer;
    rsp            = pending && (cnt == 0);
    reset          = rst;
    imem_req_ready = rrdy;
    instr_ready    = ird;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp | stray;
    imem_rdata     = (stray || (rsp && pend_dbeef)) ? 32'hDEAD_BEEF : mem_fn(pend_addr);
    #1;
    exp_rv = !rst && !pending && !buf_full;
    exp_iv = !rst && buf_full && !redir;
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check_eq("imem_addr", imem_addr, exp_pc);
    check_eq("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr", instr, mem_fn(exp_pc));
    end
    if (rst && prev_rst) begin
      check_eq("rst_instr", instr, 32'h0);
      check_eq("rst_instr_pc", instr_pc, 32'h0);
    end
    xfer = exp_iv && ird;
    if (rst) begin
      pending  = 0;
      squash   = 0;
      buf_full = 0;
      exp_pc   = ResetPc;
    end else begin
      if (rsp) begin
        pending = 0;
        if (!squash && !redir) buf_full = 1;
        squash = 0;
      end else if (pending) begin
        cnt--;
      end
      if (xfer) begin
        buf_full = 0;
        exp_pc   = exp_pc + 32'd4;
      end
      if (exp_rv && rrdy) begin
        pending    = 1;
        cnt        = lat - 1;
        squash     = redir;
        pend_addr  = imem_addr;
        pend_dbeef = dbeef;
      end else if (redir && pending) begin
        squash = 1;
      end
      if (redir) begin
        exp_pc   = {rpc[31:2], 2'b00};
        buf_full = 0;
      end
    end
    prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 32'h0, 0);
  endtask

  task automatic reach_req();
    for (int i = 0; i < 20 && (pending || buf_full); i++) step(0, 0, 1, 0, 32'h0, 0);
    check_eq("reach_req", {31'h0, !pending && !buf_full}, 32'h1);
  endtask

  task automatic reach_hold();
    for (int i = 0; i < 20 && !buf_full; i++) step(0, 1, 0, 0, 32'h0, 0);
    check_eq("reach_hold", {31'h0, buf_full}, 32'h1);
  endtask

  initial begin
    logic [31:0] rpc;
    // Reset, then free-run with a zero-wait memory: fetches 0, 4, 8, 12 every third cycle.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h0, 0);
    lat = 1;
    run_free(12);

    // Decode backpressure for 5 cycles while an instruction is buffered.
    reach_hold();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'h0, 0);
    run_free(4);

    // Memory stalls the request for 4 cycles, then responds 3 cycles late.
    reach_req();
    lat = 3;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 32'h0, 0);
    run_free(10);

    // Redirect while waiting on 0x10; its 0xDEADBEEF response must be squashed.
    reach_req();
    step(0, 0, 1, 1, 32'h0000_0010, 0);
    dbeef = 1;
    step(0, 1, 1, 0, 32'h0, 0);
    dbeef = 0;
    step(0, 0, 1, 1, 32'h0000_0200, 0);
    lat = 1;
    run_free(10);

    // Redirect in HOLD with decode ready, to an unaligned target.
    reach_hold();
    step(0, 1, 1, 1, 32'h0000_0203, 0);
    run_free(6);

    // Redirect in the same cycle the memory accepts the old address.
    reach_req();
    lat = 2;
    step(0, 1, 1, 1, 32'h0000_0304, 0);
    run_free(8);

    // PC wrap from 0xFFFFFFFC to 0.
    reach_req();
    lat = 1;
    step(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    run_free(8);

    // Reset during WAIT followed by a late response while back in REQ.
    reach_req();
    lat = 5;
    step(0, 1, 1, 0, 32'h0, 0);
    step(0, 1, 1, 0, 32'h0, 0);
    step(1, 1, 1, 0, 32'h0, 0);
    step(0, 0, 1, 0, 32'h0, 1);
    lat = 1;
    run_free(8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else rpc = $urandom & 32'h0000_0FFF;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, rpc, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
